// File: rtl/sram_emu_pkg.sv
// Shared types and constants for the SRAM bus emulator.
package sram_emu_pkg;

    localparam int unsigned SRAM_AW    = 19;
    localparam int unsigned SRAM_DW    = 8;
    localparam int unsigned MEM_AW_DEF = 10;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

endpackage

// File: rtl/sram_emu_mem.sv
// Single-port synchronous RAM, registered read, write-first; no reset.
module sram_emu_mem #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
            rdata_q       <= wdata_i;
        end else begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_bus_emulator.sv
// Responder for the async 8-bit SRAM pin bus: synchronizers, access FSM,
// activity counters and the shared-bus tristate driver.
module sram_bus_emulator
    import sram_emu_pkg::*;
#(
    parameter int unsigned MEM_AW      = MEM_AW_DEF,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SRAM_AW-1:0]  sram_adr,
    input  logic                sram_ce_n,
    input  logic                sram_we_n,
    input  logic                sram_oe_n,
    input  logic                sram_ub,
    input  logic                sram_lb,
    inout  wire  [SRAM_DW-1:0]  sram_dat,
    output logic                busy,
    output logic [CNT_W-1:0]    wr_count,
    output logic [CNT_W-1:0]    rd_count
);

    localparam int unsigned SYNC_W = MEM_AW + SRAM_DW + 5;
    localparam logic [SYNC_W-1:0] SYNC_RST = {{(MEM_AW + SRAM_DW){1'b0}}, 5'b11111};

    // Upper address bits alias away; the sink keeps them visibly consumed.
    logic adr_hi_unused;
    assign adr_hi_unused = ^sram_adr[SRAM_AW-1:MEM_AW];

    logic [SYNC_W-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
        end else begin
            sync_q[0] <= {sram_adr[MEM_AW-1:0], sram_dat,
                          sram_ce_n, sram_we_n, sram_oe_n, sram_ub, sram_lb};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    logic [MEM_AW-1:0]  adr_s;
    logic [SRAM_DW-1:0] dat_s;
    logic ce_s, we_s, oe_s, ub_s, lb_s, lane;

    assign {adr_s, dat_s, ce_s, we_s, oe_s, ub_s, lb_s} = sync_q[SYNC_STAGES-1];
    assign lane = ~ub_s | ~lb_s;

    state_e             state_q, state_d;
    logic [MEM_AW-1:0]  wr_addr_q, wr_addr_d;
    logic [MEM_AW-1:0]  rd_addr_q, rd_addr_d;
    logic [SRAM_DW-1:0] wdata_q, wdata_d;
    logic               rd_valid_q, rd_valid_d;
    logic               busy_q;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic               commit, rd_start;

    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        wdata_d    = wdata_q;
        rd_valid_d = 1'b0;
        commit     = 1'b0;
        rd_start   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (~ce_s & lane) begin
                    if (~we_s) begin
                        state_d   = ST_WRITE;
                        wr_addr_d = adr_s;
                    end else if (~oe_s) begin
                        state_d   = ST_READ;
                        rd_addr_d = adr_s;
                        rd_start  = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                // Commit the byte latched on the previous cycle, not the exit-cycle sample.
                if (we_s | ce_s) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wdata_d = dat_s;
                end
            end
            ST_READ: begin
                if (ce_s | oe_s | ~we_s) begin
                    state_d = ST_IDLE;
                end else if (adr_s != rd_addr_q) begin
                    rd_addr_d = adr_s;
                end else begin
                    rd_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (commit && !(&wr_cnt_q))   wr_cnt_d = wr_cnt_q + 1'b1;
        if (rd_start && !(&rd_cnt_q)) rd_cnt_d = rd_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            wdata_q    <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            wdata_q    <= wdata_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= (state_d != ST_IDLE);
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
        end
    end

    logic                mem_we;
    logic [MEM_AW-1:0]  mem_addr;
    logic [SRAM_DW-1:0] mem_rdata;

    assign mem_we   = commit & ~reset;
    assign mem_addr = mem_we ? wr_addr_q : rd_addr_q;

    sram_emu_mem #(
        .AW (MEM_AW),
        .DW (SRAM_DW)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    // Raw pins gate the driver so the bus is released without synchronizer lag.
    logic drive_en;
    assign drive_en = (state_q == ST_READ) & rd_valid_q & ~sram_oe_n & ~sram_ce_n
                      & sram_we_n & ~reset;
    assign sram_dat = drive_en ? mem_rdata : 'z;

    assign busy     = busy_q;
    assign wr_count = wr_cnt_q;
    assign rd_count = rd_cnt_q;

endmodule
